// File: rtl/reg_file_sb_if.sv
// Register file / scoreboard port bundle.
// Decode and writeback drive it (master); the register file serves it (slave).
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              mark;
  logic [ADDR_W-1:0] mark_addr;
  logic              busy1;
  logic              busy2;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output we, waddr, wdata,
    output raddr1, raddr2,
    output mark, mark_addr,
    input  rdata1, rdata2,
    input  busy1, busy2,
    input  pend_cnt
  );

  modport slave (
    input  we, waddr, wdata,
    input  raddr1, raddr2,
    input  mark, mark_addr,
    output rdata1, rdata2,
    output busy1, busy2,
    output pend_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file: 2 async reads, 1 sync write, optional x0,
// optional write bypass, and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  reg_file_sb_if.slave rf
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DEPTH-1:0]  set_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic [CNT_W-1:0]  pend_q;
  logic [CNT_W-1:0]  pend_nxt;

  logic wr_ok;
  logic mk_ok;
  logic zr1;
  logic zr2;
  logic byp1;
  logic byp2;

  assign wr_ok = rf.we &&
    !(ZERO_REG && rf.waddr == '0);
  assign mk_ok = rf.mark &&
    !(ZERO_REG && rf.mark_addr == '0);

  // Set beats clear: a new producer
  // issued on the writeback cycle.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (mk_ok)
      set_vec[rf.mark_addr] = 1'b1;
    if (wr_ok)
      clr_vec[rf.waddr] = 1'b1;
    busy_nxt = set_vec | (busy & ~clr_vec);
  end

  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      pend_nxt = pend_nxt + CNT_W'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy   <= '0;
      pend_q <= '0;
    end else begin
      if (wr_ok)
        regs[rf.waddr] <= rf.wdata;
      busy   <= busy_nxt;
      pend_q <= pend_nxt;
    end
  end

  assign zr1 = ZERO_REG && rf.raddr1 == '0;
  assign zr2 = ZERO_REG && rf.raddr2 == '0;

  assign byp1 = BYPASS && wr_ok &&
    rf.waddr == rf.raddr1;
  assign byp2 = BYPASS && wr_ok &&
    rf.waddr == rf.raddr2;

  assign rf.rdata1 = (rst || zr1) ? '0 :
    byp1 ? rf.wdata : regs[rf.raddr1];
  assign rf.rdata2 = (rst || zr2) ? '0 :
    byp2 ? rf.wdata : regs[rf.raddr2];

  assign rf.busy1 = !rst && !zr1 &&
    !byp1 && busy[rf.raddr1];
  assign rf.busy2 = !rst && !zr2 &&
    !byp2 && busy[rf.raddr2];

  assign rf.pend_cnt = pend_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a ZERO_REG=1/BYPASS=1 and a
// ZERO_REG=0/BYPASS=0 instance share one stimulus stream.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic        mark = 1'b0;
  logic [4:0]  mark_addr = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

  assign ifa.we = we;
  assign ifa.waddr = waddr;
  assign ifa.wdata = wdata;
  assign ifa.raddr1 = raddr1;
  assign ifa.raddr2 = raddr2;
  assign ifa.mark = mark;
  assign ifa.mark_addr = mark_addr;
  assign ifb.we = we;
  assign ifb.waddr = waddr;
  assign ifb.wdata = wdata;
  assign ifb.raddr1 = raddr1;
  assign ifb.raddr2 = raddr2;
  assign ifb.mark = mark;
  assign ifb.mark_addr = mark_addr;

  reg_file_sb #(
    .DATA_W(32), .ADDR_W(5),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (.clk(clk), .rst(rst), .rf(ifa));

  reg_file_sb #(
    .DATA_W(32), .ADDR_W(5),
    .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .rf(ifb));

  typedef struct packed {
    logic [31:0] r1a, r2a;
    logic        b1a, b2a;
    logic [5:0]  pa;
    logic [31:0] r1b, r2b;
    logic        b1b, b2b;
    logic [5:0]  pb;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  logic [31:0] mreg  [2][32];
  logic        mbusy [2][32];
  bit          zr  [2] = '{1'b1, 1'b0};
  bit          byp [2] = '{1'b1, 1'b0};

  function automatic bit wr(int k, logic [4:0] a);
    return !(zr[k] && a == 5'd0);
  endfunction

  function automatic bit hit(int k, logic [4:0] a);
    return byp[k] && we && wr(k, waddr) && waddr == a;
  endfunction

  function automatic logic [31:0] mrd(int k, logic [4:0] a);
    if (rst || (zr[k] && a == 5'd0)) return '0;
    if (hit(k, a)) return wdata;
    return mreg[k][a];
  endfunction

  function automatic logic mbz(int k, logic [4:0] a);
    if (rst || (zr[k] && a == 5'd0)) return 1'b0;
    if (hit(k, a)) return 1'b0;
    return mbusy[k][a];
  endfunction

  function automatic logic [5:0] mcnt(int k);
    logic [5:0] c = '0;
    for (int i = 0; i < 32; i++)
      if (mbusy[k][i]) c = c + 6'd1;
    return c;
  endfunction

  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          mreg[k][i] = '0;
          mbusy[k][i] = 1'b0;
        end
      end else begin
        if (we && wr(k, waddr)) begin
          mreg[k][waddr] = wdata;
          mbusy[k][waddr] = 1'b0;
        end
        if (mark && wr(k, mark_addr))
          mbusy[k][mark_addr] = 1'b1;
      end
    end
  endtask

  task automatic step();
    rec_t e;
    rec_t o;
    #1;
    e.r1a = mrd(0, raddr1);
    e.r2a = mrd(0, raddr2);
    e.b1a = mbz(0, raddr1);
    e.b2a = mbz(0, raddr2);
    e.pa  = rst ? 6'd0 : mcnt(0);
    e.r1b = mrd(1, raddr1);
    e.r2b = mrd(1, raddr2);
    e.b1b = mbz(1, raddr1);
    e.b2b = mbz(1, raddr2);
    e.pb  = rst ? 6'd0 : mcnt(1);
    exp_q.push_back(e);
    @(negedge clk);
    o = {ifa.rdata1, ifa.rdata2, ifa.busy1,
         ifa.busy2, ifa.pend_cnt, ifb.rdata1,
         ifb.rdata2, ifb.busy1, ifb.busy2,
         ifb.pend_cnt};
    obs_q.push_back(o);
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    mark = 1'b0;
  endtask

  task automatic test_reset();
    rec_t e, o;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i < 5; i++) begin
      we = 1'b1;
      waddr = 5'(i);
      wdata = 32'h1111_0000 + i;
      mark = (i == 2);
      mark_addr = 5'd2;
      step();
    end
    rst = 1'b1;
    we = 1'b1;
    waddr = 5'd1;
    wdata = 32'hCAFE_F00D;
    raddr1 = 5'd1;
    raddr2 = 5'd2;
    #1;
    checks++;
    if (ifa.rdata1 !== 32'h0 || ifb.rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata act=%h/%h exp=0",
               ifa.rdata1, ifb.rdata1);
    end
    checks++;
    if (ifa.busy2 !== 1'b0 || ifb.busy2 !== 1'b0 ||
        ifa.pend_cnt !== 6'd0 || ifb.pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL rst_busy act=%b%b cnt=%0d/%0d exp=0",
               ifa.busy2, ifb.busy2, ifa.pend_cnt, ifb.pend_cnt);
    end
    step();
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (ifb.rdata1 !== 32'h0 || ifb.busy2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_after act=%h busy=%b exp=0",
               ifb.rdata1, ifb.busy2);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      step();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_sb act=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_bypass();
    rec_t e, o;
    we = 1'b1;
    waddr = 5'd5;
    wdata = 32'h1234_5678;
    raddr1 = 5'd5;
    raddr2 = 5'd4;
    step();
    wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (ifa.rdata1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL byp_same act=%h exp=deadbeef", ifa.rdata1);
    end
    checks++;
    if (ifb.rdata1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL nobyp_old act=%h exp=12345678", ifb.rdata1);
    end
    step();
    idle();
    #1;
    checks++;
    if (ifb.rdata1 !== 32'hDEAD_BEEF ||
        ifa.rdata1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL byp_next act=%h/%h exp=deadbeef",
               ifa.rdata1, ifb.rdata1);
    end
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bypass_sb act=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_zero();
    rec_t e, o;
    we = 1'b1;
    waddr = 5'd0;
    wdata = 32'hFFFF_FFFF;
    mark = 1'b1;
    mark_addr = 5'd0;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    #1;
    checks++;
    if (ifa.rdata1 !== 32'h0 || ifa.busy1 !== 1'b0) begin
      errors++;
      $display("FAIL zero_same act=%h busy=%b exp=0",
               ifa.rdata1, ifa.busy1);
    end
    step();
    idle();
    #1;
    checks++;
    if (ifa.rdata1 !== 32'h0 || ifa.busy1 !== 1'b0 ||
        ifa.pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL zero_x0 act=%h b=%b cnt=%0d exp=0/0/0",
               ifa.rdata1, ifa.busy1, ifa.pend_cnt);
    end
    checks++;
    if (ifb.rdata1 !== 32'hFFFF_FFFF || ifb.busy1 !== 1'b1 ||
        ifb.pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL zero_r0 act=%h b=%b cnt=%0d exp=ffffffff/1/1",
               ifb.rdata1, ifb.busy1, ifb.pend_cnt);
    end
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL zero_sb act=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_mark_clear();
    rec_t e, o;
    mark = 1'b1;
    mark_addr = 5'd3;
    step();
    idle();
    raddr2 = 5'd3;
    #1;
    checks++;
    if (ifa.busy2 !== 1'b1 || ifa.pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL mark_busy act=%b cnt=%0d exp=1/1",
               ifa.busy2, ifa.pend_cnt);
    end
    step();
    we = 1'b1;
    waddr = 5'd3;
    wdata = 32'h0000_0333;
    #1;
    checks++;
    if (ifa.busy2 !== 1'b0 || ifb.busy2 !== 1'b1) begin
      errors++;
      $display("FAIL clr_same act=%b/%b exp=0/1",
               ifa.busy2, ifb.busy2);
    end
    step();
    idle();
    #1;
    checks++;
    if (ifa.pend_cnt !== 6'd0 || ifb.busy2 !== 1'b0) begin
      errors++;
      $display("FAIL clr_after cnt=%0d b=%b exp=0/0",
               ifa.pend_cnt, ifb.busy2);
    end
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL markclr_sb act=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_set_wins();
    rec_t e, o;
    mark = 1'b1;
    mark_addr = 5'd7;
    raddr1 = 5'd7;
    step();
    we = 1'b1;
    waddr = 5'd7;
    wdata = 32'hA5A5_A5A5;
    step();
    idle();
    #1;
    checks++;
    if (ifa.busy1 !== 1'b1 || ifa.pend_cnt !== 6'd1 ||
        ifa.rdata1 !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL set_wins b=%b cnt=%0d d=%h exp=1/1/a5a5a5a5",
               ifa.busy1, ifa.pend_cnt, ifa.rdata1);
    end
    checks++;
    if (ifb.busy1 !== 1'b1 || ifb.rdata1 !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL set_wins0 b=%b d=%h exp=1/a5a5a5a5",
               ifb.busy1, ifb.rdata1);
    end
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL setwin_sb act=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_fill_random();
    rec_t e, o;
    mark = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mark_addr = 5'(i);
      raddr1 = 5'(i);
      step();
    end
    mark_addr = 5'd9;
    step();
    idle();
    #1;
    checks++;
    if (ifb.pend_cnt !== 6'd32 || ifa.pend_cnt !== 6'd31) begin
      errors++;
      $display("FAIL fill_cnt act=%0d/%0d exp=31/32",
               ifa.pend_cnt, ifb.pend_cnt);
    end
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      mark = ($urandom_range(0, 3) == 0);
      mark_addr = 5'($urandom_range(0, 31));
      raddr1 = 5'($urandom_range(0, 31));
      raddr2 = (n % 4 == 0) ? waddr : 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random_sb act=%h exp=%h", o, e);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mreg[k][i] = '0;
        mbusy[k][i] = 1'b0;
      end
    @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_zero();
    test_mark_clear();
    test_set_wins();
    test_fill_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
